// File: rtl/sram_stream_reader.sv
// Free-running SRAM sample reader: walks base..end (optionally looping), holding each
// address for WAIT_CYCLES clocks, and buffers the words in a small FIFO for the codec.
module sram_stream_reader #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [3:0]    WAIT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [3:0]        waitCnt_q, waitCnt_d;
  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic pop;
  logic room;
  logic push;

  assign sample_valid = (count_q != '0);
  assign sample       = sample_valid ? mem_q[rdPtr_q] : '0;
  assign busy         = (state_q != IDLE);
  assign SRAM_ADDR    = addr_q;
  assign SRAM_CE_N    = (state_q != ACCESS);
  assign SRAM_OE_N    = (state_q != ACCESS);
  assign SRAM_WE_N    = 1'b1;
  assign SRAM_UB_N    = 1'b0;
  assign SRAM_LB_N    = 1'b0;

  // A full FIFO still has room when the consumer pops on the same edge.
  assign pop  = sample_valid && sample_ready;
  assign room = (count_q != DEPTH_C) || pop;
  assign push = (state_q == ACCESS) && (waitCnt_q == WAIT_LAST) && room && !stop;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    base_d    = base_q;
    end_d     = end_q;
    waitCnt_d = waitCnt_q;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          base_d    = base_addr;
          end_d     = end_addr;
          addr_d    = base_addr;
          waitCnt_d = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (waitCnt_q != WAIT_LAST) begin
          waitCnt_d = waitCnt_q + 4'd1;
        end else if (push) begin
          waitCnt_d = '0;
          if (addr_q != end_q) begin
            addr_d = addr_q + ADDR_W'(1);
          end else if (loop_en) begin
            addr_d = base_q;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!sample_valid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      done    = 1'b0;
    end
  end

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (stop) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)  rdPtr_d = rdPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      base_q    <= '0;
      end_q     <= '0;
      waitCnt_q <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      end_q     <= end_d;
      waitCnt_q <= waitCnt_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset; the head word is masked while the FIFO is empty.
  always_ff @(posedge Clk) begin
    if (push && !reset) mem_q[wrPtr_q] <= SRAM_DQ;
  end

endmodule

// File: doc/sram_stream_reader.md
# sram_stream_reader

Parametrised, free-running SRAM sample reader for the audio path. On `start` it reads every word from `base_addr` to `end_addr` inclusive, with a programmable number of access cycles per word, and pushes each word into an internal FIFO. The FIFO feeds a valid/ready sample port that the audio codec interface consumes. Optional loop mode restarts at `base_addr` indefinitely, which supports sustained song playback. The block replaces the single-step, button-driven SRAM read FSM: it owns the SRAM read-side control pins and sits between the SRAM pads and the audio sample consumer.

## Interface
Parameters:
- `ADDR_W`, 20, SRAM address width.
- `DATA_W`, 16, SRAM/sample word width.
- `WAIT_CYCLES`, 2, clock cycles each word is held on the bus before capture; legal range 1..15.
- `FIFO_DEPTH`, 4, sample FIFO entries; power of two, ≥2.

Ports. One clock; reset is synchronous and active-high.
- `Clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a stream; sampled only in IDLE.
- `stop`  in  1  abort the stream; honoured in any state and takes priority over `start`.
- `loop_en`  in  1  1 = wrap to `base_addr` after `end_addr`; sampled every cycle.
- `base_addr`  in  ADDR_W  first word address; latched on an accepted `start`.
- `end_addr`  in  ADDR_W  last word address, inclusive; latched on an accepted `start`.
- `SRAM_DQ`  in  DATA_W  SRAM read data.
- `SRAM_ADDR`  out  ADDR_W  registered SRAM address.
- `SRAM_CE_N`, `SRAM_OE_N`  out  1  active-low; driven low only in ACCESS.
- `SRAM_WE_N`  out  1  constant 1; the block never writes.
- `SRAM_UB_N`, `SRAM_LB_N`  out  1  constant 0.
- `sample`  out  DATA_W  FIFO head word.
- `sample_valid`  out  1  FIFO not empty.
- `sample_ready`  in  1  consumer accepts `sample` this cycle.
- `busy`  out  1  1 in any state except IDLE.
- `done`  out  1  one-cycle pulse when a non-looping stream fully drains.

## Operation
- States: IDLE, ACCESS, DRAIN.
- **IDLE**
  - If `start` is high and `stop` is low: latch `base_addr`/`end_addr`, set `SRAM_ADDR = base_addr`, clear the wait counter, go to ACCESS.
- **ACCESS**
  - Hold `SRAM_ADDR` while the wait counter counts 0..WAIT_CYCLES-1.
  - Capture happens on the edge where the counter equals WAIT_CYCLES-1 and the FIFO has room. Room means count < FIFO_DEPTH, or a pop occurs in the same cycle.
  - On capture: push `SRAM_DQ`, clear the counter, then advance the address:
    - `SRAM_ADDR ≠ end_addr`: `SRAM_ADDR + 1`, modulo 2^ADDR_W. If `base_addr > end_addr`, the sequence wraps through 0.
    - `SRAM_ADDR = end_addr` and `loop_en = 1`: address becomes the latched base.
    - `SRAM_ADDR = end_addr` and `loop_en = 0`: go to DRAIN.
  - FIFO full at terminal count: the counter saturates and the address holds until room appears. No word is dropped or read twice.
- **DRAIN**
  - `CE_N`/`OE_N` are high.
  - When the FIFO is empty, pulse `done` for one cycle and go to IDLE.
- **stop**
  - From any state, the next state is IDLE. The FIFO is flushed (`sample_valid` = 0), `CE_N`/`OE_N` go high, and `done` is not pulsed.
- **start outside IDLE**: ignored.
- **FIFO**
  - Pop when `sample_valid && sample_ready`.
  - Simultaneous push and pop keeps the count unchanged.
  - Data order is strictly address order.
- **base_addr = end_addr**: exactly one word is read per pass.

## Timing
- Reset values:
  - state IDLE; `SRAM_ADDR` 0; `SRAM_CE_N`/`SRAM_OE_N` 1; `SRAM_WE_N` 1; `SRAM_UB_N`/`SRAM_LB_N` 0.
  - `sample` 0; `sample_valid` 0; `busy` 0; `done` 0; FIFO empty.
- Reset in mid-stream behaves like `stop` and also forces the reset values above.
- Start latency:
  - `start` sampled at edge T.
  - Cycle T+1: ACCESS, `SRAM_ADDR = base_addr`, `OE_N` = 0.
  - First capture at edge T+WAIT_CYCLES.
  - `sample_valid` = 1 from cycle T+WAIT_CYCLES onward.
- Throughput: one word per WAIT_CYCLES cycles when the FIFO is not full.
- `sample` is valid in the same cycle `sample_valid` is high. After a pop, the next entry is presented on the following cycle.
- `done` is asserted in the cycle after the last pop, and the state is IDLE on the edge that ends that cycle.

## Test plan
- WAIT_CYCLES=2, base=0x10, end=0x13, `sample_ready` held 1, SRAM model returns data = address → samples 0x10..0x13 in order. First `sample_valid` appears 2 cycles after `start`. `done` pulses once, and `busy` falls one cycle after `done`.
- `sample_ready` = 0 with FIFO_DEPTH=4, range 0..9 → exactly 4 entries, then `SRAM_ADDR` holds at 4. Releasing ready delivers 0..9 with no loss or duplicates.
- `loop_en` = 1, base=5, end=6, 10 pops → sequence 5,6,5,6,…; no `done`. Clearing `loop_en` lets the stream end after the next 6, followed by `done`.
- base=0xFFFFE, end=0x00001 → addresses FFFFE, FFFFF, 00000, 00001 in order, then `done`.
- `stop` asserted mid-ACCESS with 2 entries buffered → next cycle IDLE, `sample_valid` = 0, `OE_N` = 1, no `done`. A `start` asserted together with `stop` is ignored.
- `reset` asserted for 1 cycle mid-stream → all outputs at reset values on the next cycle. A subsequent `start` works normally from the new base.
